// File: rtl/countdown_timer.sv
// Loadable 8-bit down-counter paced by a rate divider, with done pulse and
// two active-low 7-segment digits showing the current count in hex.
module countdown_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int DIV_W    = 26
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       run,
    output logic [7:0] count,
    output logic       busy,
    output logic       done,
    output logic [6:0] hex0,
    output logic [6:0] hex1
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

    state_t           state;
    logic [DIV_W-1:0] prescaler;

    // Load overrides everything; RUN is never entered or kept with count==0,
    // so the counter cannot wrap below zero.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            count     <= '0;
            prescaler <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                count     <= load_value;
                prescaler <= '0;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (run && count != 8'd0) begin
                            state     <= RUN;
                            prescaler <= '0;
                        end
                    end
                    RUN: begin
                        if (!run) begin
                            state <= PAUSE;
                        end else if (prescaler == TICK_LAST) begin
                            prescaler <= '0;
                            count     <= count - 8'd1;
                            if (count == 8'd1) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            prescaler <= prescaler + DIV_W'(1);
                        end
                    end
                    PAUSE: begin
                        if (run) begin
                            state <= RUN;
                        end
                    end
                    DONE: begin
                        count <= '0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy = (state == RUN);

    // Glyphs are written g..a so bit0 is segment a; a low bit lights a segment.
    function automatic logic [6:0] seg7(input logic [3:0] nibble);
        logic [6:0] glyph;
        case (nibble)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0011000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
        endcase
        return glyph;
    endfunction

    assign hex0 = seg7(count[3:0]);
    assign hex1 = seg7(count[7:4]);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: two timers (TICK_DIV=4 and TICK_DIV=1) share stimulus
// and are compared every cycle against an edge-counting reference model.
module tb_countdown_timer;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clock;
    logic       clear;
    logic       load;
    logic [7:0] load_value;
    logic       run;

    logic [7:0] dutCount [2];
    logic       dutBusy  [2];
    logic       dutDone  [2];
    logic [6:0] dutHex0  [2];
    logic [6:0] dutHex1  [2];

    int testsRun  = 0;
    int failCount = 0;

    // Reference model: count = loaded value - (counted RUN edges / divider)
    int divOf   [2] = '{4, 1};
    int mVal    [2];
    int mEdges  [2];
    int mMode   [2];
    bit mDone   [2];

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    countdown_timer #(.TICK_DIV(4), .DIV_W(8)) dut0 (
        .clock      (clock),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .run        (run),
        .count      (dutCount[0]),
        .busy       (dutBusy[0]),
        .done       (dutDone[0]),
        .hex0       (dutHex0[0]),
        .hex1       (dutHex1[0])
    );

    countdown_timer #(.TICK_DIV(1), .DIV_W(4)) dut1 (
        .clock      (clock),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .run        (run),
        .count      (dutCount[1]),
        .busy       (dutBusy[1]),
        .done       (dutDone[1]),
        .hex0       (dutHex0[1]),
        .hex1       (dutHex1[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] expCount(input int i);
        if (mMode[i] == M_IDLE) return 8'(mVal[i]);
        return 8'(mVal[i] - mEdges[i] / divOf[i]);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mVal[i]   = 0;
            mEdges[i] = 0;
            mMode[i]  = M_IDLE;
            mDone[i]  = 1'b0;
        end
    endtask

    task automatic modelStep();
        for (int i = 0; i < 2; i++) begin
            mDone[i] = 1'b0;
            if (!clear) begin
                mVal[i]   = 0;
                mEdges[i] = 0;
                mMode[i]  = M_IDLE;
            end else if (load) begin
                mVal[i]   = int'(load_value);
                mEdges[i] = 0;
                mMode[i]  = M_IDLE;
            end else begin
                case (mMode[i])
                    M_IDLE: if (run && mVal[i] != 0) begin
                        mMode[i]  = M_RUN;
                        mEdges[i] = 0;
                    end
                    M_RUN: if (!run) begin
                        mMode[i] = M_PAUSE;
                    end else begin
                        mEdges[i]++;
                        if (mVal[i] - mEdges[i] / divOf[i] == 0) begin
                            mMode[i] = M_DONE;
                            mDone[i] = 1'b1;
                        end
                    end
                    M_PAUSE: if (run) mMode[i] = M_RUN;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic checkAll();
        logic [7:0] c;
        for (int i = 0; i < 2; i++) begin
            c = expCount(i);
            checkOutput($sformatf("count[%0d]", i), 32'(dutCount[i]), 32'(c));
            checkOutput($sformatf("busy[%0d]", i), 32'(dutBusy[i]), 32'(mMode[i] == M_RUN));
            checkOutput($sformatf("done[%0d]", i), 32'(dutDone[i]), 32'(mDone[i]));
            checkOutput($sformatf("hex0[%0d]", i), 32'(dutHex0[i]), 32'(glyph[c[3:0]]));
            checkOutput($sformatf("hex1[%0d]", i), 32'(dutHex1[i]), 32'(glyph[c[7:4]]));
        end
    endtask

    // Drive inputs, let one rising edge pass, then compare on the falling edge.
    task automatic applyStimulus(input logic ld, input logic [7:0] lv, input logic rn);
        load       = ld;
        load_value = lv;
        run        = rn;
        @(posedge clock);
        modelStep();
        @(negedge clock);
        checkAll();
    endtask

    task automatic asyncClear();
        clear = 1'b0;
        #1;
        modelReset();
        checkAll();
    endtask

    initial begin
        clear      = 1'b0;
        load       = 1'b0;
        load_value = 8'h00;
        run        = 1'b0;
        modelReset();
        repeat (2) @(negedge clock);
        checkAll();
        clear = 1'b1;

        // Reset in the middle of a countdown, with no clock edge
        applyStimulus(1'b1, 8'h2A, 1'b0);
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 8'h00, 1'b1);
        asyncClear();
        checkOutput("clear count", 32'(dutCount[0]), 32'h0);
        checkOutput("clear hex1", 32'(dutHex1[0]), 32'b1000000);
        applyStimulus(1'b0, 8'h00, 1'b1);
        clear = 1'b1;
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("run alone busy", 32'(dutBusy[0]), 32'h0);

        // Basic countdown of 3
        applyStimulus(1'b1, 8'h03, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 12; k++) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t2 done at 12", 32'(dutDone[0]), 32'h1);
        for (int k = 0; k < 20; k++) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t2 hold zero", 32'(dutCount[0]), 32'h0);
        checkOutput("t2 done gone", 32'(dutDone[0]), 32'h0);

        // Pause and resume keeps the prescaler phase
        applyStimulus(1'b1, 8'h05, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t3 frozen", 32'(dutCount[0]), 32'h4);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t3 before", 32'(dutCount[0]), 32'h4);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t3 after", 32'(dutCount[0]), 32'h3);

        // Load wins over a decrement edge
        applyStimulus(1'b1, 8'h10, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 8'h80, 1'b1);
        checkOutput("t4 count", 32'(dutCount[1]), 32'h80);
        checkOutput("t4 busy", 32'(dutBusy[1]), 32'h0);

        // Display decode for every value
        for (int v = 0; v < 256; v++) applyStimulus(1'b1, 8'(v), 1'b0);
        applyStimulus(1'b1, 8'h9C, 1'b0);
        checkOutput("t5 hex1 9C", 32'(dutHex1[0]), 32'b0011000);
        checkOutput("t5 hex0 9C", 32'(dutHex0[0]), 32'b1000110);

        // Edge values with TICK_DIV=1
        applyStimulus(1'b1, 8'h01, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t6 one done", 32'(dutDone[1]), 32'h1);
        applyStimulus(1'b1, 8'hFF, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t6 FE", 32'(dutCount[1]), 32'hFE);
        for (int k = 0; k < 254; k++) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t6 FF done", 32'(dutDone[1]), 32'h1);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 8'h00, 1'b1);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic       ld;
            logic [7:0] lv;
            logic       rn;
            ld = ($urandom_range(0, 31) == 0);
            lv = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 6))
                                             : 8'($urandom_range(0, 255));
            rn = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 199) == 0) begin
                asyncClear();
                #1;
                clear = 1'b1;
            end
            applyStimulus(ld, lv, rn);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
